// File: rtl/fb_pixel_stream_pkg.sv
// fb_pixel_stream_pkg: shared colour codes, tag type and sizing helpers for the frame-buffer scan engine.
package fb_pixel_stream_pkg;

    localparam int WHITE  = 0;
    localparam int BLACK  = 1;
    localparam int RED    = 2;
    localparam int BLUE   = 3;
    localparam int GREEN  = 4;
    localparam int YELLOW = 5;

    typedef struct packed {
        logic vld;
        logic sof;
        logic eol;
    } tag_t;

    // Two spare slots beyond the read latency keep issue running at full rate.
    function automatic int fifo_depth(input int rom_lat);
        return rom_lat + 2;
    endfunction

    // Channel ch (2=R, 1=G, 0=B) of default palette entry code is fully on.
    function automatic logic def_on(input int code, input int ch);
        logic [2:0] m;
        m = code == WHITE  ? 3'b111 :
            code == RED    ? 3'b100 :
            code == BLUE   ? 3'b001 :
            code == GREEN  ? 3'b010 :
            code == YELLOW ? 3'b110 : 3'b000;
        return m[2'(ch)];
    endfunction

endpackage

// File: rtl/fb_pixel_stream_pix_fifo.sv
// pix_fifo: synchronous FIFO with fall-through on empty so a push can be popped in the same cycle.
module pix_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [W-1:0]     wdata_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [W-1:0]     rdata_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q, wr_d, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty, wr, rd;

    assign empty   = count_q == '0;
    assign valid_o = !empty | push_i;
    assign rdata_o = empty ? wdata_i : mem_q[rd_q];
    assign count_o = count_q;
    assign wr      = push_i & !(empty & pop_i);
    assign rd      = pop_i & !empty;
    assign wr_d    = !wr ? wr_q : wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
    assign rd_d    = !rd ? rd_q : rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
    assign count_d = count_q + CNT_W'(wr) - CNT_W'(rd);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i)
        if (wr) mem_q[wr_q] <= wdata_i;

endmodule

// File: rtl/fb_pixel_stream.sv
// fb_pixel_stream: raster-order frame-buffer reader with latency-absorbing FIFO and writable palette.
module fb_pixel_stream
    import fb_pixel_stream_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 19,
    parameter int CODE_W     = 3,
    parameter int COLOR_W    = 4,
    parameter int ROM_LAT    = 1,
    parameter int START_ADDR = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 en,
    output logic [ADDR_W-1:0]    addra,
    output logic                 rd_en,
    input  logic [CODE_W-1:0]    douta,
    input  logic                 pal_we,
    input  logic [CODE_W-1:0]    pal_idx,
    input  logic [3*COLOR_W-1:0] pal_rgb,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [COLOR_W-1:0]   R,
    output logic [COLOR_W-1:0]   G,
    output logic [COLOR_W-1:0]   B,
    output logic                 sof,
    output logic                 eol
);
    localparam int DEPTH     = fifo_depth(ROM_LAT);
    localparam int NPIX      = H_ACTIVE * V_ACTIVE;
    localparam int CW        = $clog2(DEPTH + 1);
    localparam int HW        = H_ACTIVE > 1 ? $clog2(H_ACTIVE) : 1;
    localparam int NPAL      = 2 ** CODE_W;
    localparam int START_COL = START_ADDR % H_ACTIVE;

    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [HW-1:0]        col_q, col_d;
    logic [CW-1:0]        infl_q, infl_d, f_count;
    tag_t                 tag_q [ROM_LAT];
    logic [3*COLOR_W-1:0] pal_q [NPAL];
    logic [3*COLOR_W-1:0] rgb_q;
    logic                 vld_q, sof_q, eol_q;
    logic                 credit, push, f_valid, load;
    logic [CODE_W+1:0]    f_rdata;
    logic [CODE_W-1:0]    head_code;

    // Reads already issued plus those buffered may never exceed the FIFO size.
    assign credit    = ({1'b0, infl_q} + {1'b0, f_count}) < (CW + 1)'(DEPTH);
    assign rd_en     = RST & en & credit;
    assign addra     = addr_q;
    assign addr_d    = !rd_en ? addr_q : addr_q == ADDR_W'(NPIX - 1) ? '0 : addr_q + 1'b1;
    assign col_d     = !rd_en ? col_q : col_q == HW'(H_ACTIVE - 1) ? '0 : col_q + 1'b1;
    assign push      = tag_q[ROM_LAT-1].vld;
    assign infl_d    = infl_q + CW'(rd_en) - CW'(push);
    assign load      = f_valid & (!vld_q | pix_ready);
    assign head_code = f_rdata[CODE_W+1:2];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            addr_q <= ADDR_W'(START_ADDR);
            col_q  <= HW'(START_COL);
            infl_q <= '0;
            for (int i = 0; i < ROM_LAT; i++) tag_q[i] <= '0;
        end else begin
            addr_q   <= addr_d;
            col_q    <= col_d;
            infl_q   <= infl_d;
            tag_q[0] <= '{vld: rd_en, sof: addr_q == '0, eol: col_q == HW'(H_ACTIVE - 1)};
            for (int i = 1; i < ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    pix_fifo #(
        .W     (CODE_W + 2),
        .DEPTH (DEPTH),
        .CNT_W (CW)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .push_i  (push),
        .wdata_i ({douta, tag_q[ROM_LAT-1].sof, tag_q[ROM_LAT-1].eol}),
        .pop_i   (load),
        .valid_o (f_valid),
        .rdata_o (f_rdata),
        .count_o (f_count)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < NPAL; i++)
                pal_q[i] <= {{COLOR_W{def_on(i, 2)}}, {COLOR_W{def_on(i, 1)}}, {COLOR_W{def_on(i, 0)}}};
        end else if (pal_we) begin
            pal_q[pal_idx] <= pal_rgb;
        end
    end

    // Lookup reads the palette before any same-cycle write lands.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            vld_q <= 1'b0;
            rgb_q <= '0;
            sof_q <= 1'b0;
            eol_q <= 1'b0;
        end else if (load) begin
            vld_q <= 1'b1;
            rgb_q <= pal_q[head_code];
            sof_q <= f_rdata[1];
            eol_q <= f_rdata[0];
        end else if (pix_ready) begin
            vld_q <= 1'b0;
        end
    end

    assign pix_valid = vld_q;
    assign {R, G, B} = rgb_q;
    assign sof       = sof_q;
    assign eol       = eol_q;

endmodule
